// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - dot-product sequencer around a three-stage signed MAC pipeline
//
// Optional feature macro: MAC_DOT_SAT_EN
//   defined   : accumulator saturates at signed AW limits, ovf is sticky per job
//   undefined : accumulator wraps modulo 2^AW, ovf tied to 0
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start, len            job request and operand-pair count (sampled in IDLE)
//   busy                  high whenever the sequencer is not IDLE
//   in_valid, in_ready    operand-pair handshake
//   dataa, datab          signed operands
//   res_valid, res_ready  result handshake
//   result                accumulator value (meaningful while res_valid)
//   ovf                   sticky saturation flag for the current job
module mac_dot_seq #(
  parameter int N  = 8,
  parameter int LW = 8,
  parameter int AW = 2*N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LW-1:0]        len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [N-1:0]  dataa,
  input  logic signed [N-1:0]  datab,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic signed [AW-1:0] result,
  output logic                 ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  logic [1:0]              state;
  logic [LW-1:0]           remaining;
  logic signed [N-1:0]     a1, b1;
  logic                    v1;
  logic signed [2*N-1:0]   p2;
  logic                    v2;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    prod_ext;
  logic signed [AW-1:0]    acc_add;
  logic                    beat;
  logic                    job_start;
  logic                    sat_hit;

  assign in_ready  = (state == S_STREAM);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_RESULT);
  assign result    = acc;
  assign beat      = in_ready && in_valid;
  assign job_start = (state == S_IDLE) && start;

  // Size cast sign-extends the signed product when AW > 2N and truncates when AW < 2N.
  assign prod_ext = AW'(p2);

`ifdef MAC_DOT_SAT_EN
  logic signed [AW:0] sum_wide;
  assign sum_wide = {acc[AW-1], acc} + {prod_ext[AW-1], prod_ext};
  // Overflow shows up as disagreement between the guard bit and the AW sign bit.
  assign sat_hit  = (sum_wide[AW] != sum_wide[AW-1]);
  always_comb begin
    acc_add = sum_wide[AW-1:0];
    if (sat_hit) begin
      acc_add = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end
  end
`else
  assign sat_hit = 1'b0;
  assign acc_add = acc + prod_ext;
`endif

  // Sequencer, length counter and accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      acc       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc <= '0;
            if (len != '0) begin
              remaining <= len;
              state     <= S_STREAM;
            end else begin
              state     <= S_RESULT;
            end
          end
        end
        S_STREAM: begin
          if (beat) begin
            remaining <= remaining - 1'b1;
            if (remaining == LW'(1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Both pipeline stages empty means the last product is already in acc.
          if (!v1 && !v2) state <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (v2) acc <= acc_add;
    end
  end

  // MAC pipeline: operand register, product register; bubbles carry v=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1 <= '0;
      b1 <= '0;
      v1 <= 1'b0;
      p2 <= '0;
      v2 <= 1'b0;
    end else begin
      v1 <= beat;
      if (beat) begin
        a1 <= dataa;
        b1 <= datab;
      end
      v2 <= v1;
      if (v1) p2 <= a1 * b1;
    end
  end

`ifdef MAC_DOT_SAT_EN
  logic ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (job_start) begin
      ovf_q <= 1'b0;
    end else if (v2 && sat_hit) begin
      ovf_q <= 1'b1;
    end
  end
  assign ovf = ovf_q;
`else
  logic unused_ok;
  assign unused_ok = job_start ^ sat_hit;
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - self-checking bench for mac_dot_seq
module tb_mac_dot_seq;

  localparam int N  = 8;
  localparam int LW = 8;
  localparam int AW = 16;
  localparam longint HI  = (longint'(1) <<< (AW-1)) - 1;
  localparam longint LO  = -(longint'(1) <<< (AW-1));
  localparam longint MOD = longint'(1) <<< AW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [LW-1:0]        len = '0;
  logic                 busy;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [N-1:0]  dataa = '0;
  logic signed [N-1:0]  datab = '0;
  logic                 res_valid;
  logic                 res_ready = 1'b0;
  logic signed [AW-1:0] result;
  logic                 ovf;

  int tests = 0;
  int fails = 0;
  int qa [0:15];
  int qb [0:15];

  mac_dot_seq #(.N(N), .LW(LW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .dataa(dataa), .datab(datab),
    .res_valid(res_valid), .res_ready(res_ready), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: sum of products, then either modular wrap or per-add clamping.
  function automatic longint model(input int n, output bit o);
    longint s = 0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s += longint'(qa[i]) * longint'(qb[i]);
`ifdef MAC_DOT_SAT_EN
      if (s > HI) begin s = HI; o = 1'b1; end
      else if (s < LO) begin s = LO; o = 1'b1; end
`endif
    end
`ifndef MAC_DOT_SAT_EN
    s = s % MOD;
    if (s < 0) s += MOD;
    if (s > HI) s -= MOD;
`endif
    return s;
  endfunction

  task automatic do_job(input string tag, input int n, input bit bubbles,
                        input int stall, input bit poke);
    longint exp;
    bit     eo;
    bit     v, tog, acc_beat;
    int     i, guard, lat;
    exp = model(n, eo);
    start = 1'b1;
    len   = LW'(n);
    tick();
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ovf_clr"}, ovf, 0);
    if (n == 0) begin
      check({tag, "_zl_rv"}, res_valid, 1);
      check({tag, "_zl_ir"}, in_ready, 0);
    end else begin
      check({tag, "_ir"}, in_ready, 1);
      i = 0; guard = 0; tog = 1'b1;
      while (i < n && guard < 200) begin
        v = bubbles ? tog : 1'b1;
        tog = !tog;
        in_valid = v;
        dataa = N'(qa[i]);
        datab = N'(qb[i]);
        start = (poke && guard == 1);
        len   = LW'(1);
        acc_beat = v && in_ready;
        tick();
        guard++;
        if (acc_beat) i++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      check({tag, "_beats"}, i, n);
      check({tag, "_drain_ir"}, in_ready, 0);
      lat = 0;
      while (!res_valid && lat < 20) begin
        tick();
        lat++;
      end
      check({tag, "_latency"}, lat, 3);
    end
    check({tag, "_result"}, result, exp);
    check({tag, "_ovf"}, ovf, eo);
    for (int s = 0; s < stall; s++) begin
      start = poke;
      tick();
    end
    start = 1'b0;
    if (stall > 0) begin
      check({tag, "_stall_rv"}, res_valid, 1);
      check({tag, "_stall_res"}, result, exp);
      check({tag, "_stall_ir"}, in_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_rv"}, res_valid, 0);
  endtask

  initial begin
    bit dummy;
    #2;
    check("rst_flags", {busy, in_ready, res_valid, ovf}, 0);
    check("rst_result", result, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic job.
    qa[0] = 2;  qb[0] = 3;
    qa[1] = -4; qb[1] = 5;
    qa[2] = 7;  qb[2] = -1;
    check("basic_model", model(3, dummy), -21);
    do_job("basic", 3, 1'b0, 0, 1'b0);

    // Backpressure on both sides.
    for (int i = 0; i < 4; i++) begin qa[i] = 1; qb[i] = 1; end
    do_job("bp", 4, 1'b1, 5, 1'b0);

    // Zero length.
    do_job("zero", 0, 1'b0, 0, 1'b0);

    // Overflow / saturation, then ovf clears at next start.
    for (int i = 0; i < 4; i++) begin qa[i] = -128; qb[i] = -128; end
    do_job("ovf", 4, 1'b0, 0, 1'b0);
    qa[0] = 1; qb[0] = 1;
    do_job("ovf_next", 1, 1'b0, 0, 1'b0);

    // in_valid in IDLE is ignored.
    in_valid = 1'b1; dataa = 8'sd9; datab = 8'sd9;
    for (int c = 0; c < 3; c++) tick();
    check("idle_ir", in_ready, 0);
    check("idle_busy", busy, 0);
    in_valid = 1'b0;

    // start pulsed during STREAM and RESULT is ignored.
    for (int i = 0; i < 5; i++) begin qa[i] = i + 1; qb[i] = -(i + 2); end
    do_job("poke", 5, 1'b0, 3, 1'b1);

    // Reset in the middle of a job.
    start = 1'b1; len = LW'(5);
    tick();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1; dataa = 8'sd100; datab = 8'sd100;
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_flags", {busy, in_ready, res_valid, ovf}, 0);
    check("midrst_result", result, 0);
    tick();
    rst = 1'b0;
    tick();
    qa[0] = 3; qb[0] = 3;
    qa[1] = 1; qb[1] = 2;
    do_job("after_rst", 2, 1'b0, 0, 1'b0);
    check("after_rst_val", result, 11);

    // Randomized jobs against the reference.
    for (int j = 0; j < 6; j++) begin
      int n;
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        qa[i] = int'($urandom_range(0, 255)) - 128;
        qb[i] = int'($urandom_range(0, 255)) - 128;
      end
      do_job("rand", n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer for a pipelined signed multiply-accumulate datapath that computes one dot product per job. It accepts a job request with a length, streams operand pairs through a valid/ready handshake, and clears the accumulator at job start. It then drains the MAC pipeline and presents the final sum through a result handshake. It sits between an operand producer (memory walker or DMA) and any consumer of scalar results, and it owns the MAC datapath internally.

## Interface
- N, 8: operand width (signed)
- LW, 8: length-counter width; max job length 2^LW-1
- AW, 2*N: accumulator/result width (signed)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  job request; sampled only in IDLE
- len  in  LW  number of operand pairs for the job; captured with start
- busy  out  1  high whenever state is not IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  sequencer accepts an operand pair
- dataa, datab  in  N  signed operands
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  AW  signed dot-product sum
- ovf  out  1  sticky overflow flag for the current job (see Configuration)

## Operation
- States: IDLE, STREAM, DRAIN, RESULT.
- IDLE: busy=0, in_ready=0, res_valid=0. If start=1 and len!=0: capture len into remaining, clear accumulator and ovf, go to STREAM. If start=1 and len==0: clear accumulator and ovf, go to RESULT.
- STREAM: in_ready=1. A beat is accepted when in_valid&in_ready. An accepted beat loads dataa/datab into stage-1 registers with valid v1, and decrements remaining. On the beat where remaining==1, go to DRAIN. in_ready drops in the following cycle.
- Pipeline, signed throughout:
  - Stage 1 registers the operands.
  - Stage 2 registers the 2N-bit product with v2.
  - Stage 3 adds the product, sign-extended (or truncated if AW<2N) to AW, into the accumulator when v2=1.
  - Bubbles (v=0) never change the accumulator.
- DRAIN: in_ready=0. Wait until v1=0 and v2=0, then go to RESULT.
- RESULT: res_valid=1, result=accumulator, held stable. On res_valid&res_ready, go to IDLE.
- start outside IDLE is ignored. in_valid outside STREAM is ignored.
- result reflects the accumulator in all states. It is only meaningful while res_valid=1.
- Asynchronous rst, including mid-job: state=IDLE, and accumulator, remaining, pipeline registers, v1, v2 and ovf all go to 0. All outputs read 0. No partial result is emitted.

## Timing
- Reset values: busy=0, in_ready=0, res_valid=0, result=0, ovf=0.
- start accepted at edge s: busy=1 and in_ready=1 from edge s.
- Last beat accepted at edge k:
  - stage 1 at k
  - product at k+1
  - accumulator final at k+2
  - state RESULT and res_valid=1 from edge k+3
- Fixed latency: 3 cycles from last handshake to res_valid, independent of bubbles.
- len==0: res_valid=1 from the edge after start is accepted.
- Streaming throughput: one pair per cycle with no bubbles.
- Result handshake at edge r: IDLE from r. A new start is sampled at r+1 at the earliest.

## Configuration
- MAC_DOT_SAT_EN defined:
  - The accumulator saturates at the signed AW limits, +2^(AW-1)-1 and -2^(AW-1).
  - ovf is set on any saturating add and stays set until the next job start or rst.
- MAC_DOT_SAT_EN undefined:
  - The accumulator wraps modulo 2^AW.
  - ovf is tied to 0.

## Test plan
- Basic job: N=8, AW=16, len=3, pairs (2,3),(-4,5),(7,-1) back-to-back, res_ready=1 → result=-21, res_valid exactly 3 cycles after the last handshake, busy=0 the cycle after the result handshake.
- Backpressure: len=4, all pairs (1,1), in_valid toggled 1-0-1-0, res_ready held 0 for 5 cycles → result=4, held stable with res_valid=1 through the stall, in_ready=0 in DRAIN/RESULT.
- Zero length: start with len=0 → res_valid=1 one cycle later, result=0, no beats accepted.
- Overflow: len=4, all pairs (-128,-128) (16384 each), AW=16 → without macro result=0 and ovf=0; with MAC_DOT_SAT_EN result=32767 and ovf=1; ovf clears on the next start.
- Reset mid-job: rst asserted after 2 of 5 beats → all outputs 0 immediately; a subsequent job with len=2, pairs (3,3),(1,2) → result=11 with no residue from the aborted job.
- Ignored inputs: start pulsed during STREAM and RESULT, in_valid=1 in IDLE → no state change, no extra beats accumulated, remaining count unaffected.
